pll_ctrl: RTL and testbench

PLL_CTRL -- requirements
Module: pll_ctrl

---
 rtl/pll_ctrl.sv | 126 ++++++++++++
 tb/tb_pll_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_ctrl.sv
// pll_ctrl: sequences PLL reset, qualifies lock stability and applies divider reconfiguration
module pll_ctrl #(
    parameter int         RST_CYCLES   = 16,
    parameter int         LOCK_STABLE  = 1024,
    parameter int         LOCK_TIMEOUT = 65535,
    parameter logic [5:0] IDSEL_INIT   = 6'd0,
    parameter logic [5:0] FBDSEL_INIT  = 6'd0,
    parameter logic [5:0] ODSEL_INIT   = 6'd0
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    output logic       clk_ok,
    output logic       lock_lost,
    output logic [7:0] retry_cnt
);
    localparam int MAX_CNT = (LOCK_TIMEOUT > LOCK_STABLE)
        ? ((LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES)
        : ((LOCK_STABLE > RST_CYCLES) ? LOCK_STABLE : RST_CYCLES);
    localparam int CW = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {RESET_HOLD, WAIT_LOCK, STABLE, RUN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          lock_m, lock_s;
    logic          accept;
    logic          pll_reset_d, run_d, lock_lost_d;
    logic [7:0]    retry_d;
    logic [5:0]    idsel_d, fbdsel_d, odsel_d;

    // cfg_ready mirrors "in RUN", so a handshake is only possible there
    assign accept = cfg_ready & cfg_valid;

    // two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    // state, shared counter and registered outputs
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RESET_HOLD;
            cnt        <= '0;
            pll_reset  <= 1'b1;
            pll_idsel  <= IDSEL_INIT;
            pll_fbdsel <= FBDSEL_INIT;
            pll_odsel  <= ODSEL_INIT;
            cfg_ready  <= 1'b0;
            clk_ok     <= 1'b0;
            lock_lost  <= 1'b0;
            retry_cnt  <= 8'd0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pll_reset  <= pll_reset_d;
            pll_idsel  <= idsel_d;
            pll_fbdsel <= fbdsel_d;
            pll_odsel  <= odsel_d;
            cfg_ready  <= run_d;
            clk_ok     <= run_d;
            lock_lost  <= lock_lost_d;
            retry_cnt  <= retry_d;
        end
    end

    // next state: the counter times the reset hold, the lock timeout and the stable run
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        case (state)
            RESET_HOLD: if (cnt == RST_LAST) begin
                state_n = WAIT_LOCK;
                cnt_n   = '0;
            end
            WAIT_LOCK: if (lock_s) begin
                state_n = (LOCK_STABLE <= 1) ? RUN : STABLE;
                cnt_n   = CW'(1);
            end else if (cnt == TO_LAST) begin
                state_n = RESET_HOLD;
                cnt_n   = '0;
            end
            STABLE: if (!lock_s) begin
                state_n = WAIT_LOCK;
                cnt_n   = '0;
            end else if (cnt == STB_LAST) begin
                state_n = RUN;
                cnt_n   = '0;
            end
            default: begin
                cnt_n = '0;
                if (!lock_s || accept) state_n = RESET_HOLD;
            end
        endcase
    end

    // output values taken on the same edge as the transition they belong to
    always_comb begin
        pll_reset_d = state_n == RESET_HOLD;
        run_d       = state_n == RUN;
        lock_lost_d = state == RUN && !lock_s;
        retry_d     = (state == WAIT_LOCK && state_n == RESET_HOLD && retry_cnt != 8'hff)
                      ? retry_cnt + 8'd1 : retry_cnt;
        idsel_d     = accept ? cfg_idsel  : pll_idsel;
        fbdsel_d    = accept ? cfg_fbdsel : pll_fbdsel;
        odsel_d     = accept ? cfg_odsel  : pll_odsel;
    end
endmodule

// File: tb/tb_pll_ctrl.sv
// tb_pll_ctrl: scoreboard bench comparing pll_ctrl against a behavioural lock-sequencing model
module tb_pll_ctrl;
    localparam int RC = 4;
    localparam int LS = 8;
    localparam int LT = 32;

    logic       clkin = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [5:0] cfg_idsel = '0, cfg_fbdsel = '0, cfg_odsel = '0;
    logic       pll_reset, cfg_ready, clk_ok, lock_lost;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic [7:0] retry_cnt;

    int tests = 0;
    int fails = 0;
    logic [29:0] sb[$];
    logic [29:0] exp_v, act_v;

    pll_ctrl #(
        .RST_CYCLES(RC), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT),
        .IDSEL_INIT(6'd0), .FBDSEL_INIT(6'd0), .ODSEL_INIT(6'd0)
    ) dut (
        .clkin(clkin), .rst_n(rst_n), .pll_lock(pll_lock), .pll_reset(pll_reset),
        .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idsel(cfg_idsel),
        .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel), .clk_ok(clk_ok),
        .lock_lost(lock_lost), .retry_cnt(retry_cnt)
    );

    always #5 clkin = ~clkin;

    typedef enum {M_HOLD, M_WAIT, M_STABLE, M_RUN} phase_t;
    phase_t     ph;
    int         hold_left, wait_left, seen, retries;
    bit         s1, s2, lost;
    logic [5:0] m_id, m_fb, m_od;

    function automatic void m_reset();
        ph = M_HOLD; hold_left = RC; wait_left = LT; seen = 0; retries = 0;
        s1 = 0; s2 = 0; lost = 0; m_id = 6'd0; m_fb = 6'd0; m_od = 6'd0;
    endfunction

    function automatic logic [29:0] m_out();
        logic [7:0] r;
        r = retries[7:0];
        return {ph == M_HOLD, m_id, m_fb, m_od, ph == M_RUN, ph == M_RUN, lost, r};
    endfunction

    // one clock edge of the reference behaviour, using the lock value seen two edges ago
    function automatic void m_step();
        bit ls;
        ls = s2;
        lost = 0;
        case (ph)
            M_HOLD: begin
                hold_left--;
                if (hold_left == 0) begin ph = M_WAIT; wait_left = LT; end
            end
            M_WAIT: if (ls) begin
                seen = 1;
                ph = (seen == LS) ? M_RUN : M_STABLE;
            end else begin
                wait_left--;
                if (wait_left == 0) begin
                    ph = M_HOLD; hold_left = RC;
                    if (retries < 255) retries++;
                end
            end
            M_STABLE: if (!ls) begin
                ph = M_WAIT; wait_left = LT;
            end else begin
                seen++;
                if (seen == LS) ph = M_RUN;
            end
            default: begin
                if (cfg_valid) begin m_id = cfg_idsel; m_fb = cfg_fbdsel; m_od = cfg_odsel; end
                lost = !ls;
                if (cfg_valid || !ls) begin ph = M_HOLD; hold_left = RC; end
            end
        endcase
        s2 = s1;
        s1 = pll_lock;
    endfunction

    task automatic cyc(input bit l, input bit v, input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
        pll_lock = l; cfg_valid = v; cfg_idsel = i; cfg_fbdsel = f; cfg_odsel = o;
        @(posedge clkin);
        if (!rst_n) m_reset(); else m_step();
        sb.push_back(m_out());
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: every edge's outputs against the queued expectation
    initial forever begin
        @(negedge clkin);
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            act_v = {pll_reset, pll_idsel, pll_fbdsel, pll_odsel, cfg_ready, clk_ok, lock_lost, retry_cnt};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL outputs @%0t: got %h expected %h (reset,id,fb,od,ready,ok,lost,retry)",
                         $time, act_v, exp_v);
            end
        end
    end

    initial begin
        bit l;
        int r0;
        m_reset();
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("reset pll_reset", int'(pll_reset), 1);
        chk("reset clk_ok", int'(clk_ok), 0);
        chk("reset cfg_ready", int'(cfg_ready), 0);
        chk("reset retry", int'(retry_cnt), 0);
        rst_n = 1'b1;

        repeat (RC - 1) cyc(0, 0, 0, 0, 0);
        chk("pll_reset held", int'(pll_reset), 1);
        cyc(0, 0, 0, 0, 0);
        chk("pll_reset falls", int'(pll_reset), 0);
        repeat (9) cyc(1, 0, 0, 0, 0);
        chk("clk_ok before 10th edge", int'(clk_ok), 0);
        cyc(1, 0, 0, 0, 0);
        chk("clk_ok on 10th edge", int'(clk_ok), 1);
        chk("cfg_ready in run", int'(cfg_ready), 1);

        cyc(1, 1, 6'd4, 6'd1, 6'd16);
        chk("accept idsel", int'(pll_idsel), 4);
        chk("accept fbdsel", int'(pll_fbdsel), 1);
        chk("accept odsel", int'(pll_odsel), 16);
        chk("accept pll_reset", int'(pll_reset), 1);
        chk("accept clk_ok", int'(clk_ok), 0);
        chk("accept cfg_ready", int'(cfg_ready), 0);
        repeat (RC - 1) cyc(1, 0, 0, 0, 0);
        chk("reconfig reset held", int'(pll_reset), 1);
        cyc(1, 0, 0, 0, 0);
        chk("reconfig reset falls", int'(pll_reset), 0);
        repeat (LS) cyc(1, 0, 0, 0, 0);
        chk("relock clk_ok", int'(clk_ok), 1);

        repeat (2) cyc(0, 0, 0, 0, 0);
        chk("run before loss seen", int'(clk_ok), 1);
        cyc(0, 1, 6'd7, 6'd9, 6'd33);
        chk("loss lock_lost", int'(lock_lost), 1);
        chk("loss clk_ok", int'(clk_ok), 0);
        chk("loss+cfg idsel", int'(pll_idsel), 7);
        chk("loss+cfg odsel", int'(pll_odsel), 33);
        cyc(0, 0, 0, 0, 0);
        chk("lock_lost one cycle", int'(lock_lost), 0);
        repeat (RC - 2) cyc(0, 0, 0, 0, 0);

        r0 = int'(retry_cnt);
        repeat (5) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (9) cyc(1, 0, 0, 0, 0);
        chk("glitch delays clk_ok", int'(clk_ok), 0);
        cyc(1, 0, 0, 0, 0);
        chk("clk_ok after restart", int'(clk_ok), 1);
        chk("glitch retry unchanged", int'(retry_cnt), r0);

        repeat (3 + RC + LT) cyc(0, 0, 0, 0, 0);
        chk("first timeout retry", int'(retry_cnt), 1);
        chk("timeout re-pulse", int'(pll_reset), 1);
        repeat (RC + LT) cyc(0, 0, 0, 0, 0);
        chk("second timeout retry", int'(retry_cnt), 2);
        repeat (300 * (RC + LT)) cyc(0, 0, 0, 0, 0);
        chk("retry saturates", int'(retry_cnt), 255);

        repeat (RC + LS + 4) cyc(1, 0, 0, 0, 0);
        chk("run before reconfig", int'(clk_ok), 1);
        cyc(1, 1, 6'd12, 6'd34, 6'd56);
        repeat (RC + 5) cyc(0, 0, 0, 0, 0);
        @(negedge clkin);
        #1 rst_n = 1'b0;
        #1;
        chk("async pll_reset", int'(pll_reset), 1);
        chk("async idsel", int'(pll_idsel), 0);
        chk("async fbdsel", int'(pll_fbdsel), 0);
        chk("async odsel", int'(pll_odsel), 0);
        chk("async retry", int'(retry_cnt), 0);
        chk("async clk_ok", int'(clk_ok), 0);
        m_reset();
        repeat (2) cyc(0, 0, 0, 0, 0);
        rst_n = 1'b1;

        l = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 29) == 0) l = ~l;
            cyc(l, $urandom_range(0, 7) == 0, 6'($urandom), 6'($urandom), 6'($urandom));
        end

        repeat (3) @(negedge clkin);
        chk("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
